lsu_sequencer: RTL and testbench
================================

// Module: lsu_sequencer
// PURPOSE
//  Multi-cycle load/store sequencer between the decode/control stage and data memory.
//  Accepts one load or store per start pulse and latches it. Drives a req/gnt/rvalid memory handshake.
//  Generates byte enables and lane-replicated write data, then extracts and extends load data.
//  Holds the pipeline via busy; reports misalignment, illegal func3 and timeout faults.
// PARAMETERS
//  TIMEOUT  16  cycles spent in REQ+RESP before the access is aborted with a timeout fault (>=2)
//  CNT_W    5   width of the timeout counter; must hold TIMEOUT
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  start        in   1   access request from pipeline (load_enable | store_enable)
//  is_store     in   1   1 = store, 0 = load; sampled with start
//  func3        in   3   RV32I width/sign code; sampled with start
//  addr         in   32  effective byte address; sampled with start
//  wdata        in   32  store data (rs2); sampled with start
//  busy         out  1   pipeline stall; high in REQ and RESP
//  done         out  1   one-cycle completion pulse (DONE state)
//  rdata        out  32  extended load result; valid when done, held until next done
//  fault        out  1   high with done when the access faulted
//  fault_cause  out  2   01 misaligned, 10 illegal func3, 11 timeout, 00 none
//  mem_req      out  1   memory request; held until mem_gnt
//  mem_we       out  1   1 = write
//  mem_be       out  4   byte-lane enables
//  mem_addr     out  32  word address {addr[31:2],2'b00}
//  mem_wdata    out  32  lane-replicated write data
//  mem_gnt      in   1   memory accepted the request this cycle
//  mem_rvalid   in   1   response valid; read data, or write ack
//  mem_rdata    in   32  read data word
// BEHAVIOUR
//  Reset: state IDLE, counter 0. All outputs 0: busy, done, rdata, fault, fault_cause, mem_*.
//  States: IDLE, REQ, RESP, DONE. All outputs are registered or decoded from state only.
//  Acceptance: start accepted in IDLE or DONE; fields latched that edge. start in REQ/RESP ignored.
//  Accepted access, valid: next state REQ.
//  Accepted access, faulting: next state DONE with the fault; mem_req is never raised.
//  Illegal func3: store 011-111; load 011, 110, 111. Illegal func3 takes priority over misaligned.
//  Misaligned: halfword (x01) with addr[0]=1; word (010) with addr[1:0]!=0.
//  REQ: mem_req=1; mem_we/be/addr/wdata stable until gnt. gnt -> RESP; mem_req low from the next cycle.
//  RESP: wait for mem_rvalid (load and store alike), then DONE.
//  rvalid in the same cycle as gnt is not sampled; a response is counted only in RESP.
//  DONE: lasts exactly 1 cycle with done=1, then IDLE unless a new start is accepted.
//  Minimum latency: start@T0, mem_req@T1, gnt@T1, rvalid@T2, done@T3.
//  Byte enables: sb 0001<<addr[1:0]; sh 0011<<{addr[1],1'b0}; sw 1111. Loads drive be the same way.
//  Write data: sb {4{wdata[7:0]}}; sh {2{wdata[15:0]}}; sw wdata.
//  Loads: select lane by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
//  rdata is written 0 on a store done and on a faulting done.
//  Timeout: counter clears on accept and increments each cycle in REQ/RESP.
//  On reaching TIMEOUT: go to DONE, fault=1, cause 11, mem_req dropped.
//  mem_rvalid and mem_gnt are ignored in IDLE and DONE (late responses discarded).
//  Reset mid-access: IDLE on the next edge; any outstanding response is discarded.
// TESTING
//  lw addr 0x100, gnt@T1, rvalid@T2 data 0xDEADBEEF -> mem_addr 0x100, be 1111; done@T3; rdata 0xDEADBEEF; busy T1-T2.
//  lb addr 0x203, mem_rdata 0x80xxxxxx -> be 1000, rdata 0xFFFFFF80; lbu same access -> rdata 0x00000080.
//  sh addr 0x12, wdata 0x1234ABCD, gnt delayed 3 cycles -> mem_req held 4 cycles, be 1100, mem_wdata 0xABCDABCD.
//  sw addr 0x102 -> no mem_req; done next cycle, fault=1, cause 01. Store func3 011 -> cause 10.
//  TIMEOUT=16, gnt never asserted -> done 17 cycles after start, cause 11; rvalid 2 cycles later is ignored.
//  rst at RESP, then rvalid next cycle -> IDLE, done never pulses; back-to-back start in DONE accepted, no idle gap.

Source files
------------

// File: rtl/lsu_sequencer.sv
// Purpose : load/store sequencer between decode/control and data memory (req/gnt/rvalid).
// Latency : start -> done in 3 cycles minimum (REQ, RESP, DONE); faulting access done next cycle.
// Backpr. : o_busy stalls the pipeline in REQ/RESP; o_mem_req held until i_mem_gnt.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start, i_is_store, i_func3,
//   i_addr, i_wdata              access request, sampled when accepted (IDLE or DONE)
//   o_busy, o_done, o_rdata,
//   o_fault, o_fault_cause       pipeline status and extended load result
//   o_mem_req, o_mem_we, o_mem_be,
//   o_mem_addr, o_mem_wdata      memory request side
//   i_mem_gnt, i_mem_rvalid,
//   i_mem_rdata                  memory grant / response side
module lsu_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_is_store,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] C_NONE    = 2'b00;
  localparam logic [1:0] C_MISALGN = 2'b01;
  localparam logic [1:0] C_ILLEGAL = 2'b10;
  localparam logic [1:0] C_TIMEOUT = 2'b11;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_store;
  logic [2:0]        r_func3;
  logic [1:0]        r_lane;
  logic [31:0]       r_rdata;
  logic              r_fault;
  logic [1:0]        r_cause;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_illegal;
  logic              w_misalign;
  logic              w_fault;
  logic [1:0]        w_cause;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic              w_tmo;
  logic [CNT_W-1:0]  w_cnt_inc;

  // ---------------------------------------------------------------------------
  // Request decode on the incoming (not yet latched) fields
  // ---------------------------------------------------------------------------
  // Stores only have sb/sh/sw (000..010); loads additionally have lbu/lhu (100/101).
  always_comb begin
    if (i_is_store) begin
      w_illegal = i_func3[2] | (i_func3[1:0] == 2'b11);
    end else begin
      w_illegal = (i_func3 == 3'b011) | (i_func3[2:1] == 2'b11);
    end
  end

  // func3[1:0] encodes the access size for every legal code (00 byte, 01 half, 10 word).
  always_comb begin
    w_misalign = 1'b0;
    if (i_func3[1:0] == 2'b01) begin
      w_misalign = i_addr[0];
    end else if (i_func3[1:0] == 2'b10) begin
      w_misalign = (i_addr[1:0] != 2'b00);
    end
  end

  // Illegal func3 outranks misalignment in the reported cause.
  always_comb begin
    w_fault = w_illegal | w_misalign;
    if (w_illegal) begin
      w_cause = C_ILLEGAL;
    end else if (w_misalign) begin
      w_cause = C_MISALGN;
    end else begin
      w_cause = C_NONE;
    end
  end

  always_comb begin
    case (i_func3[1:0])
      2'b00:   w_be = 4'b0001 << i_addr[1:0];
      2'b01:   w_be = i_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Data is replicated across all lanes so the memory just applies byte enables.
  always_comb begin
    case (i_func3[1:0])
      2'b00:   w_wdata = {4{i_wdata[7:0]}};
      2'b01:   w_wdata = {2{i_wdata[15:0]}};
      default: w_wdata = i_wdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load result extraction using the latched lane and width
  // ---------------------------------------------------------------------------
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
  end

  always_comb begin
    case (r_func3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = i_mem_rdata;
    endcase
  end

  // Counter is 0 in the first REQ cycle, so TIMEOUT-1 marks the last allowed cycle.
  assign w_tmo     = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_store  <= 1'b0;
      r_func3     <= 3'd0;
      r_lane      <= 2'd0;
      r_rdata     <= 32'd0;
      r_fault     <= 1'b0;
      r_cause     <= C_NONE;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      // fault/cause only ever show alongside done
      r_fault <= 1'b0;
      r_cause <= C_NONE;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_cnt      <= '0;
            r_is_store <= i_is_store;
            r_func3    <= i_func3;
            r_lane     <= i_addr[1:0];
            if (w_fault) begin
              r_state <= S_DONE;
              r_fault <= 1'b1;
              r_cause <= w_cause;
              r_rdata <= 32'd0;
            end else begin
              r_state     <= S_REQ;
              r_mem_we    <= i_is_store;
              r_mem_be    <= w_be;
              r_mem_addr  <= {i_addr[31:2], 2'b00};
              r_mem_wdata <= w_wdata;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_REQ: begin
          // A grant in the final allowed cycle still loses to the timeout:
          // no response could arrive before the budget is spent.
          if (w_tmo) begin
            r_state <= S_DONE;
            r_fault <= 1'b1;
            r_cause <= C_TIMEOUT;
            r_rdata <= 32'd0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (i_mem_gnt) begin
              r_state <= S_RESP;
            end
          end
        end

        S_RESP: begin
          // A response landing in the final allowed cycle completes normally.
          if (i_mem_rvalid) begin
            r_state <= S_DONE;
            r_rdata <= r_is_store ? 32'd0 : w_load;
          end else if (w_tmo) begin
            r_state <= S_DONE;
            r_fault <= 1'b1;
            r_cause <= C_TIMEOUT;
            r_rdata <= 32'd0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = (r_state == S_REQ) || (r_state == S_RESP);
  assign o_done        = (r_state == S_DONE);
  assign o_mem_req     = (r_state == S_REQ);
  assign o_rdata       = r_rdata;
  assign o_fault       = r_fault;
  assign o_fault_cause = r_cause;
  assign o_mem_we      = r_mem_we;
  assign o_mem_be      = r_mem_be;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Purpose : randomized + directed check of lsu_sequencer against a transaction-timeline model.
// Latency : model predicts the done cycle of every access from its grant/response delays.
// Backpr. : memory side is driven by the bench with chosen gnt/rvalid delays plus ignored noise.
module tb_lsu_sequencer;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_is_store;
  logic [2:0]  i_func3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_fault;
  logic [1:0]  o_fault_cause;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  lsu_sequencer #(.TIMEOUT(TMO), .CNT_W(5)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_is_store    (i_is_store),
    .i_func3       (i_func3),
    .i_addr        (i_addr),
    .i_wdata       (i_wdata),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_rdata       (o_rdata),
    .o_fault       (o_fault),
    .o_fault_cause (o_fault_cause),
    .o_mem_req     (o_mem_req),
    .o_mem_we      (o_mem_we),
    .o_mem_be      (o_mem_be),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wdata   (o_mem_wdata),
    .i_mem_gnt     (i_mem_gnt),
    .i_mem_rvalid  (i_mem_rvalid),
    .i_mem_rdata   (i_mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expected outputs for the current cycle
  bit          chk_en = 1'b0;
  logic        e_busy, e_done, e_req, e_fault, e_we;
  logic [1:0]  e_cause;
  logic [3:0]  e_be;
  logic [31:0] e_rdata, e_addr, e_wdata;

  // observations used by the literal checks
  int          req_seen;
  logic [3:0]  seen_be;
  logic [31:0] seen_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference rules
  // ---------------------------------------------------------------------------
  function automatic int m_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [1:0] m_cause(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit ill;
    if (st) ill = (f3 > 3'd2);
    else    ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if (ill) return 2'd2;
    if ((int'(a[1:0]) % m_bytes(f3)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int mask;
    mask = (1 << m_bytes(f3)) - 1;
    return 4'(mask << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (m_bytes(f3))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, b, h;
    v = rd >> (8 * int'(a[1:0]));
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Single compare process
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",    32'(o_busy),    32'(e_busy));
      chk("done",    32'(o_done),    32'(e_done));
      chk("mem_req", 32'(o_mem_req), 32'(e_req));
      chk("rdata",   o_rdata,        e_rdata);
      if (e_done) begin
        chk("fault",       32'(o_fault),       32'(e_fault));
        chk("fault_cause", 32'(o_fault_cause), 32'(e_cause));
      end
      if (e_req) begin
        chk("mem_we",    32'(o_mem_we), 32'(e_we));
        chk("mem_be",    32'(o_mem_be), 32'(e_be));
        chk("mem_addr",  o_mem_addr,    e_addr);
        chk("mem_wdata", o_mem_wdata,   e_wdata);
      end
      if (o_mem_req) begin
        req_seen++;
        seen_be = o_mem_be;
        seen_wd = o_mem_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    i_mem_gnt    = 1'($urandom_range(0, 1));
    i_mem_rvalid = 1'($urandom_range(0, 1));
    i_mem_rdata  = $urandom;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      i_start = 1'b0;
      noise();
      e_busy = 1'b0; e_done = 1'b0; e_req = 1'b0;
    end
  endtask

  // Drives one access starting in the current cycle (relative cycle 0).
  // g: cycles gnt stays low after mem_req rises (<0: never); r: cycles from gnt to rvalid (>=1).
  // Returns in the done cycle with kdone = relative cycle of done.
  task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int g, input int r,
                        input logic [31:0] rd, output int kdone);
    logic [1:0] c;
    bit         tmo;
    int         req_end, done_k;
    c = m_cause(st, f3, a);
    tmo = 1'b0;
    req_end = 0;
    i_start = 1'b1; i_is_store = st; i_func3 = f3; i_addr = a; i_wdata = wd;
    noise();
    if (c != 2'd0) begin
      done_k = 1;
    end else if (g < 0 || g >= TMO - 1) begin
      tmo = 1'b1; req_end = TMO; done_k = TMO + 1;
    end else begin
      req_end = 1 + g;
      if (1 + g + r <= TMO) done_k = 2 + g + r;
      else begin tmo = 1'b1; done_k = TMO + 1; end
    end
    for (int k = 1; k <= done_k; k++) begin
      step();
      // start while busy must be ignored
      i_start = 1'($urandom_range(0, 1));
      i_is_store = 1'($urandom_range(0, 1));
      i_func3 = 3'($urandom_range(0, 7));
      i_addr = $urandom;
      i_wdata = $urandom;
      noise();
      if (k < done_k) begin
        e_busy = 1'b1; e_done = 1'b0; e_req = (k <= req_end);
        e_we = st; e_be = m_be(f3, a); e_addr = a & 32'hFFFF_FFFC; e_wdata = m_wdata(f3, wd);
        if (k <= req_end) begin
          i_mem_gnt = (g >= 0) && (k == 1 + g);
        end else begin
          i_mem_rvalid = (k == 1 + g + r);
          if (i_mem_rvalid) i_mem_rdata = rd;
        end
      end else begin
        i_start = 1'b0;
        e_busy = 1'b0; e_done = 1'b1; e_req = 1'b0;
        e_fault = (c != 2'd0) || tmo;
        e_cause = tmo ? 2'd3 : c;
        e_rdata = ((c != 2'd0) || tmo || st) ? 32'd0 : m_load(f3, a, rd);
      end
    end
    kdone = done_k;
  endtask

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int kd;
    i_rst = 1'b1; i_start = 1'b0; i_is_store = 1'b0; i_func3 = 3'd0;
    i_addr = 32'd0; i_wdata = 32'd0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'd0;
    e_busy = 1'b0; e_done = 1'b0; e_req = 1'b0; e_fault = 1'b0; e_cause = 2'd0;
    e_we = 1'b0; e_be = 4'd0; e_addr = 32'd0; e_wdata = 32'd0; e_rdata = 32'd0;
    req_seen = 0; seen_be = 4'd0; seen_wd = 32'd0;
    step();
    step();
    i_rst = 1'b0;
    chk_en = 1'b1;
    // reset state
    chk("rst_mem_we",    32'(o_mem_we),      32'd0);
    chk("rst_mem_be",    32'(o_mem_be),      32'd0);
    chk("rst_mem_addr",  o_mem_addr,         32'd0);
    chk("rst_mem_wdata", o_mem_wdata,        32'd0);
    chk("rst_fault",     32'(o_fault),       32'd0);
    chk("rst_cause",     32'(o_fault_cause), 32'd0);
    idle(2);

    // lw 0x100, minimum latency
    step(); i_start = 1'b0; noise();
    do_txn(1'b0, 3'b010, 32'h100, 32'd0, 0, 1, 32'hDEAD_BEEF, kd);
    chk("lw_done_cycle", 32'(kd), 32'd3);
    chk("lw_rdata", o_rdata, 32'hDEAD_BEEF);
    idle(2);

    // lb / lbu from lane 3
    req_seen = 0;
    do_txn(1'b0, 3'b000, 32'h203, 32'd0, 1, 2, 32'h80AB_CDEF, kd);
    chk("lb_rdata", o_rdata, 32'hFFFF_FF80);
    chk("lb_be", 32'(seen_be), 32'h8);
    idle(1);
    do_txn(1'b0, 3'b100, 32'h203, 32'd0, 0, 1, 32'h80AB_CDEF, kd);
    chk("lbu_rdata", o_rdata, 32'h0000_0080);
    idle(1);

    // sh with delayed grant
    req_seen = 0;
    do_txn(1'b1, 3'b001, 32'h12, 32'h1234_ABCD, 3, 2, 32'd0, kd);
    chk("sh_req_cycles", 32'(req_seen), 32'd4);
    chk("sh_be", 32'(seen_be), 32'hC);
    chk("sh_wdata", seen_wd, 32'hABCD_ABCD);
    chk("sh_rdata_zero", o_rdata, 32'd0);
    idle(1);

    // misaligned sw, illegal store, illegal-over-misaligned, illegal load
    req_seen = 0;
    do_txn(1'b1, 3'b010, 32'h102, 32'h5555_AAAA, 0, 1, 32'd0, kd);
    chk("sw_mis_done_cycle", 32'(kd), 32'd1);
    chk("sw_mis_fault", 32'(o_fault), 32'd1);
    chk("sw_mis_cause", 32'(o_fault_cause), 32'd1);
    idle(1);
    do_txn(1'b1, 3'b011, 32'h0, 32'h1, 0, 1, 32'd0, kd);
    chk("st_ill_cause", 32'(o_fault_cause), 32'd2);
    idle(1);
    do_txn(1'b1, 3'b101, 32'h3, 32'h1, 0, 1, 32'd0, kd);
    chk("st_ill_prio_cause", 32'(o_fault_cause), 32'd2);
    idle(1);
    do_txn(1'b0, 3'b110, 32'h0, 32'h0, 0, 1, 32'd0, kd);
    chk("ld_ill_cause", 32'(o_fault_cause), 32'd2);
    chk("fault_no_req", 32'(req_seen), 32'd0);
    idle(1);

    // timeout, grant never arrives; a late rvalid two cycles after done is ignored
    do_txn(1'b0, 3'b010, 32'h40, 32'd0, -1, 1, 32'd0, kd);
    chk("tmo_done_cycle", 32'(kd), 32'd17);
    chk("tmo_cause", 32'(o_fault_cause), 32'd3);
    step(); i_start = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    e_busy = 1'b0; e_done = 1'b0; e_req = 1'b0;
    step(); i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1111_2222;
    idle(2);

    // boundaries: grant in the last allowed cycle times out; response in it completes
    do_txn(1'b0, 3'b010, 32'h80, 32'd0, 15, 1, 32'h1234_5678, kd);
    chk("gnt_last_cycle_cause", 32'(o_fault_cause), 32'd3);
    idle(1);
    do_txn(1'b0, 3'b010, 32'h84, 32'd0, 14, 1, 32'h1234_5678, kd);
    chk("rvalid_last_cycle_done", 32'(kd), 32'd17);
    chk("rvalid_last_cycle_rdata", o_rdata, 32'h1234_5678);
    idle(1);

    // back-to-back: starts accepted in DONE with no idle gap
    do_txn(1'b0, 3'b001, 32'h22, 32'd0, 0, 1, 32'h8001_7FFF, kd);
    do_txn(1'b1, 3'b000, 32'h31, 32'h0000_00A5, 1, 1, 32'd0, kd);
    do_txn(1'b1, 3'b010, 32'h31, 32'h0, 0, 1, 32'd0, kd);
    do_txn(1'b0, 3'b101, 32'h22, 32'd0, 0, 1, 32'h8001_7FFF, kd);
    chk("b2b_lhu_rdata", o_rdata, 32'h0000_8001);
    idle(1);

    // reset while waiting for the response; the rvalid that follows is discarded
    i_start = 1'b1; i_is_store = 1'b0; i_func3 = 3'b010; i_addr = 32'h44; i_wdata = 32'h9;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    step();
    i_start = 1'b0; i_mem_gnt = 1'b1; i_mem_rvalid = 1'b0;
    e_busy = 1'b1; e_done = 1'b0; e_req = 1'b1;
    e_we = 1'b0; e_be = m_be(3'b010, 32'h44); e_addr = 32'h44; e_wdata = m_wdata(3'b010, 32'h9);
    step();
    i_mem_gnt = 1'b0; i_rst = 1'b1;
    e_req = 1'b0;
    step();
    i_rst = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
    e_busy = 1'b0; e_done = 1'b0; e_req = 1'b0; e_rdata = 32'd0;
    chk("midrst_mem_addr", o_mem_addr, 32'd0);
    idle(3);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      bit          st;
      logic [2:0]  f3;
      logic [31:0] a;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      do_txn(st, f3, a, $urandom, $urandom_range(0, 4), $urandom_range(1, 4), $urandom, kd);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
